// File: rtl/reg_file_dump_reader.sv
// Debug reader that walks the register file read port and streams each word
// on a valid/ready output while keeping a running XOR checksum.
module reg_file_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              single,
  input  logic [ADDR_W-1:0] sel_addr,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    SEND,
    DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              single_q, single_d;
  logic              last_word;

  assign last_word = single_q || (rd_addr_q == LAST_ADDR);

  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    checksum_d = checksum_q;
    single_d   = single_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rd_addr_d  = single ? sel_addr : '0;
          single_d   = single;
          checksum_d = '0;
          state_d    = SAMPLE;
        end
      end
      SAMPLE: begin
        // x0 is architecturally zero whatever the array holds
        out_data_d = (rd_addr_q == '0) ? '0 : rd_data;
        out_addr_d = rd_addr_q;
        state_d    = abort ? IDLE : SEND;
      end
      SEND: begin
        if (out_ready) begin
          checksum_d = checksum_q ^ out_data_q;
        end
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready) begin
          if (last_word) begin
            state_d = DONE;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
            state_d   = SAMPLE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      checksum_q <= '0;
      single_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      checksum_q <= checksum_d;
      single_q   <= single_d;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign out_valid = (state_q == SEND);
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_reg_file_dump_reader.sv
// Directed bench for reg_file_dump_reader with a behavioural register file
// on the read port.
module tb_reg_file_dump_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        single;
  logic [4:0]  sel_addr;
  logic        abort;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  logic [31:0] regs [32];
  int checks;
  int failures;

  reg_file_dump_reader #(
    .ADDR_W(5),
    .DATA_W(32),
    .DEPTH (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .single   (single),
    .sel_addr (sel_addr),
    .abort    (abort),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr (out_addr),
    .out_data (out_data),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  assign rd_data = regs[rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] model(input int a);
    logic [31:0] v;
    v = (a == 0) ? 32'h0 : regs[a];
    return v;
  endfunction

  // Full dump with optional stall, reset, restart or abort at given addresses
  task automatic run_full(input int stall_addr, input int stall_n,
                          input int rst_at, input int restart_at,
                          input int abort_at, input int exp_done);
    int nxt;
    int done_cnt;
    int stall_left;
    logic [31:0] cks;
    bit ended;
    bit restarted;
    nxt = 0;
    done_cnt = 0;
    stall_left = stall_n;
    cks = 0;
    ended = 0;
    restarted = 0;
    single = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lat1_valid", {31'b0, out_valid}, 32'd0);
    chk("lat1_busy", {31'b0, busy}, 32'd1);
    for (int c = 2; c <= 100 && !ended; c++) begin
      tick();
      start = 1'b0;
      out_ready = 1'b1;
      if (c == 2) chk("lat2_valid", {31'b0, out_valid}, 32'd1);
      if (done) begin
        done_cnt = c;
        ended = 1;
      end else if (!busy) begin
        ended = 1;
      end else if (out_valid) begin
        if (int'(out_addr) == rst_at) begin
          rst = 1'b1;
          #1;
          chk("rst_valid", {31'b0, out_valid}, 32'd0);
          chk("rst_busy", {31'b0, busy}, 32'd0);
          chk("rst_cks", checksum, 32'd0);
          chk("rst_rdaddr", {27'b0, rd_addr}, 32'd0);
          rst = 1'b0;
          ended = 1;
        end else if (int'(out_addr) == abort_at) begin
          abort = 1'b1;
          out_ready = 1'b0;
        end else if (int'(out_addr) == stall_addr && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          chk("stall_data", out_data, model(stall_addr));
        end else begin
          chk("word_addr", {27'b0, out_addr}, nxt);
          chk("word_data", out_data, model(nxt));
          cks ^= out_data;
          nxt++;
          if (int'(out_addr) == restart_at && !restarted) begin
            start = 1'b1;
            restarted = 1;
          end
        end
      end
    end
    abort = 1'b0;
    chk("ended", {31'b0, ended}, 32'd1);
    chk("done_cycle", done_cnt, exp_done);
    if (exp_done != 0) begin
      chk("word_count", nxt, 32);
      chk("full_cks", checksum, cks);
      tick();
      chk("done_pulse_end", {31'b0, done}, 32'd0);
      chk("idle_after", {31'b0, busy}, 32'd0);
    end else begin
      if (abort_at < 32) begin
        chk("abort_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_cks", checksum, cks);
      end
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("no_done", {31'b0, done}, 32'd0);
      end
    end
  endtask

  task automatic run_single(input vec_t v);
    single = 1'b1;
    sel_addr = v.addr;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    single = 1'b0;
    tick();
    chk("s_valid", {31'b0, out_valid}, 32'd1);
    chk("s_addr", {27'b0, out_addr}, {27'b0, v.addr});
    chk("s_data", out_data, v.data);
    tick();
    chk("s_done", {31'b0, done}, 32'd1);
    chk("s_valid_drop", {31'b0, out_valid}, 32'd0);
    chk("s_cks", checksum, v.data);
    tick();
    chk("s_done_end", {31'b0, done}, 32'd0);
    chk("s_busy_end", {31'b0, busy}, 32'd0);
    chk("s_cks_hold", checksum, v.data);
  endtask

  vec_t vecs [4];

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    regs[3] = 32'd5;
    regs[4] = 32'd7;
    start = 0;
    single = 0;
    sel_addr = 0;
    abort = 0;
    out_ready = 0;
    rst = 1'b1;
    #12;
    chk("reset_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_cks", checksum, 32'd0);
    chk("reset_rdaddr", {27'b0, rd_addr}, 32'd0);
    chk("reset_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_full(99, 0, 99, 99, 99, 65);
    chk("full_cks_const", checksum, 32'h2);
    run_full(3, 3, 99, 99, 99, 68);
    chk("stall_cks_const", checksum, 32'h2);
    run_full(99, 0, 10, 99, 99, 0);
    tick();
    run_full(99, 0, 99, 99, 99, 65);
    run_full(99, 0, 99, 5, 8, 0);
    chk("abort_cks_const", checksum, 32'h2);

    start = 1'b1;
    abort = 1'b1;
    tick();
    chk("start_abort_idle", {31'b0, busy}, 32'd1);
    start = 1'b0;
    tick();
    chk("abort_sample", {31'b0, busy}, 32'd0);
    chk("abort_sample_done", {31'b0, done}, 32'd0);
    abort = 1'b0;
    tick();

    regs[0] = 32'hDEAD;
    regs[31] = 32'hCAFE0031;
    vecs[0] = '{addr: 5'd4, data: 32'd7};
    vecs[1] = '{addr: 5'd3, data: 32'd5};
    vecs[2] = '{addr: 5'd0, data: 32'd0};
    vecs[3] = '{addr: 5'd31, data: 32'hCAFE0031};
    for (int i = 0; i < 4; i++) run_single(vecs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
